// File: rtl/reg_file_wr_sched.sv
// reg_file_wr_sched: write-port scheduler for a 32-entry register file.
// Shares the register file's single write port between NUM_REQ writeback
// requesters with round-robin arbitration. After reset, or on clear_req,
// it sequences a hardware clear of x1..x31 before granting any requester.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/reg/data    packed per-requester write requests
//   req_ready             combinational one-hot grant (zero when none)
//   clear_req             single-cycle pulse requesting a clear of x1..x31
//   stall                 blocks all grants while high
//   busy                  high while the clear sequence runs
//   wr_en/wr_reg/wr_data  registered write port to the register file
//
// Optional build macro: REG_FILE_WR_SCHED_X0_FILTER_EN
//   When defined, granted requests targeting x0 are accepted but issued
//   with wr_en=0, so no x0 write ever reaches the port.
module reg_file_wr_sched #(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_reg,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   input  logic                            clear_req,
   input  logic                            stall,
   output logic                            busy,
   output logic                            wr_en,
   output logic [ADDR_WIDTH-1:0]           wr_reg,
   output logic [DATA_WIDTH-1:0]           wr_data
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t                 state;
   logic [PTR_W-1:0]       rr_ptr;
   logic [ADDR_WIDTH-1:0]  clr_idx;

   logic [PTR_W:0]         cand;
   logic [PTR_W-1:0]       grant_idx;
   logic                   grant_any;
   logic [ADDR_WIDTH-1:0]  sel_reg;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic                   issue_en;

   // Round-robin scan starting one past the last granted requester.
   // Only valids feed the grant, never a requester's own reg/data.
   always_comb begin
      req_ready = '0;
      grant_idx = rr_ptr;
      grant_any = 1'b0;
      cand      = '0;
      if (state == ST_IDLE && !stall) begin
         for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(off);
            if (cand >= (PTR_W+1)'(NUM_REQ)) begin
               cand = cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!grant_any && req_valid[cand[PTR_W-1:0]]) begin
               grant_any = 1'b1;
               grant_idx = cand[PTR_W-1:0];
            end
         end
      end
      if (grant_any) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   // Select the granted requester's payload using the one-hot grant.
   always_comb begin
      sel_reg  = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) begin
            sel_reg  = req_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef REG_FILE_WR_SCHED_X0_FILTER_EN
   // x0 requests still handshake but never produce a port write.
   assign issue_en = grant_any && (sel_reg != '0);
`else
   assign issue_en = grant_any;
`endif

   assign busy = (state == ST_CLEAR);

   // Scheduler state, round-robin pointer and registered write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_CLEAR;
         clr_idx <= ADDR_WIDTH'(1);
         rr_ptr  <= PTR_W'(NUM_REQ - 1);
         wr_en   <= 1'b0;
         wr_reg  <= '0;
         wr_data <= '0;
      end else begin
         case (state)
            ST_CLEAR: begin
               wr_en   <= 1'b1;
               wr_reg  <= clr_idx;
               wr_data <= '0;
               clr_idx <= clr_idx + ADDR_WIDTH'(1);
               if (clr_idx == '1) begin
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               wr_en <= issue_en;
               if (grant_any) begin
                  wr_reg  <= sel_reg;
                  wr_data <= sel_data;
                  rr_ptr  <= grant_idx;
               end
               // A grant in this cycle is issued before the clear begins.
               if (clear_req) begin
                  state   <= ST_CLEAR;
                  clr_idx <= ADDR_WIDTH'(1);
               end
            end
            default: begin
               state   <= ST_CLEAR;
               clr_idx <= ADDR_WIDTH'(1);
               wr_en   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reg_file_wr_sched.sv
// Testbench for reg_file_wr_sched: a cycle-level model of the scheduling
// rules predicts grants and port writes; a monitor pops the expected write
// after every clock edge. A simple register file array, written from the
// DUT's port, is compared against a golden array at checkpoints.
module tb_reg_file_wr_sched;

   localparam int N  = 2;
   localparam int AW = 5;
   localparam int DW = 32;

`ifdef REG_FILE_WR_SCHED_X0_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_reg;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            clear_req;
   logic            stall;
   logic            busy;
   logic            wr_en;
   logic [AW-1:0]   wr_reg;
   logic [DW-1:0]   wr_data;

   reg_file_wr_sched #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_reg   (req_reg),
      .req_data  (req_data),
      .req_ready (req_ready),
      .clear_req (clear_req),
      .stall     (stall),
      .busy      (busy),
      .wr_en     (wr_en),
      .wr_reg    (wr_reg),
      .wr_data   (wr_data)
   );

   typedef struct {
      logic          en;
      logic [AW-1:0] r;
      logic [DW-1:0] d;
   } exp_t;

   exp_t          q[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   bit            mon_en   = 1'b0;

   logic [DW-1:0] rf[32] = '{default: 32'hBAD0_BAD0};
   logic [DW-1:0] golden[32];

   // Requester-side state: held until accepted.
   logic          v[N];
   logic [AW-1:0] r[N];
   logic [DW-1:0] d[N];

   // Reference model state.
   bit            m_clear;
   int            m_idx;
   int            m_last;
   int            last_grant;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file behind the write port.
   always @(posedge clk) begin
      if (wr_en && wr_reg != '0) rf[wr_reg] <= wr_data;
   end

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: one expectation per clock edge while enabled.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (mon_en) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL scoreboard_empty: actual wr_en=%b required=an expected entry", wr_en);
            end else begin
               e = q.pop_front();
               chk("wr_en", DW'(wr_en), DW'(e.en));
               if (e.en) begin
                  chk("wr_reg", DW'(wr_reg), DW'(e.r));
                  chk("wr_data", wr_data, e.d);
               end
            end
         end
      end
   end

   // Assert reset, check reset values, release on a falling edge.
   task automatic do_reset();
      mon_en  = 1'b0;
      rst_n   = 1'b0;
      q.delete();
      m_clear = 1'b1;
      m_idx   = 1;
      m_last  = N - 1;
      #1;
      chk("rst_wr_en", DW'(wr_en), 0);
      chk("rst_wr_reg", DW'(wr_reg), 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", DW'(busy), 1);
      chk("rst_req_ready", DW'(req_ready), 0);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   // One clock cycle: drive inputs, predict, check the grant, queue the write.
   task automatic step(input bit clr);
      logic [N-1:0] er;
      bit           eb;
      int           g;
      exp_t         e;
      for (int i = 0; i < N; i++) begin
         req_valid[i]           = v[i];
         req_reg[i*AW +: AW]    = r[i];
         req_data[i*DW +: DW]   = d[i];
      end
      clear_req = clr;
      #1;
      er   = '0;
      g    = -1;
      e.en = 1'b0;
      e.r  = '0;
      e.d  = '0;
      if (m_clear) begin
         eb   = 1'b1;
         e.en = 1'b1;
         e.r  = AW'(m_idx);
         golden[m_idx] = '0;
         if (m_idx == 31) m_clear = 1'b0;
         else m_idx++;
      end else begin
         eb = 1'b0;
         if (!stall) begin
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (m_last + k) % N;
               if (g < 0 && v[c]) g = c;
            end
         end
         if (g >= 0) begin
            er[g] = 1'b1;
            e.en  = !(FILT && r[g] == '0);
            e.r   = r[g];
            e.d   = d[g];
            if (r[g] != '0) golden[r[g]] = d[g];
            m_last = g;
         end
         if (clr) begin
            m_clear = 1'b1;
            m_idx   = 1;
         end
      end
      chk("req_ready", DW'(req_ready), DW'(er));
      chk("busy", DW'(busy), DW'(eb));
      q.push_back(e);
      last_grant = g;
      if (g >= 0) v[g] = 1'b0;
      @(negedge clk);
      clear_req = 1'b0;
   endtask

   initial begin
      int cnt;
      bit found;
      rst_n     = 1'b1;
      clear_req = 1'b0;
      stall     = 1'b0;
      req_valid = '0;
      req_reg   = '0;
      req_data  = '0;
      for (int i = 0; i < N; i++) begin
         v[i] = 1'b0;
         r[i] = '0;
         d[i] = '0;
      end
      for (int i = 0; i < 32; i++) golden[i] = 32'h5A5A_5A5A;
      #1;

      // Reset release: 31-cycle clear of x1..x31.
      do_reset();
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy) cnt++;
         step(1'b0);
      end
      chk("clear_len", cnt, 31);
      for (int i = 1; i < 32; i++) chk("rf_after_reset", rf[i], 0);

      // Round-robin with both requesters continuously valid.
      r[0] = 5; d[0] = 32'hAAAA_5555;
      r[1] = 6; d[1] = 32'h1234_ABCD;
      for (int k = 0; k < 4; k++) begin
         v[0] = 1'b1;
         v[1] = 1'b1;
         step(1'b0);
         chk("rr_grant", last_grant, k % 2);
      end
      step(1'b0);
      chk("rf_x5", rf[5], 32'hAAAA_5555);
      chk("rf_x6", rf[6], 32'h1234_ABCD);
      step(1'b0);

      // Stall blocks the grant for three cycles.
      v[0] = 1'b1; r[0] = 7; d[0] = $urandom;
      stall = 1'b1;
      repeat (3) step(1'b0);
      stall = 1'b0;
      step(1'b0);
      chk("stall_grant", last_grant, 0);

      // x10 write granted in the same cycle as clear_req, then the clear.
      v[0] = 1'b1; r[0] = 10; d[0] = 32'hFFFF_FFFF;
      step(1'b1);
      chk("pre_clear_grant", last_grant, 0);
      v[0] = 1'b1; r[0] = 3; d[0] = $urandom;
      v[1] = 1'b1; r[1] = 4; d[1] = $urandom;
      cnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy) cnt++;
         step(1'b0);
      end
      chk("clear_mid_len", cnt, 31);
      chk("x10_cleared", rf[10], 0);

      // x0 request: handshakes normally.
      v[0] = 1'b1; r[0] = 0; d[0] = 32'hDEAD_BEEF;
      step(1'b0);
      chk("x0_grant", last_grant, 0);
      step(1'b0);
      step(1'b0);

      // Randomized traffic with stalls and occasional clears.
      for (int k = 0; k < 400; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!v[i] && $urandom_range(0, 99) < 60) begin
               v[i] = 1'b1;
               r[i] = AW'($urandom_range(0, 31));
               d[i] = $urandom;
            end
         end
         stall = ($urandom_range(0, 7) == 0);
         step($urandom_range(0, 149) == 0);
      end
      stall = 1'b0;

      // Async reset in the middle of a clear.
      for (int k = 0; k < 40; k++) begin
         if (!m_clear) break;
         step(1'b0);
      end
      step(1'b1);
      found = 1'b0;
      for (int k = 0; k < 40; k++) begin
         step(1'b0);
         if (wr_en && wr_reg == 5'd12) begin
            found = 1'b1;
            break;
         end
      end
      chk("reach_idx12", DW'(found), 1);
      #2;
      do_reset();
      step(1'b0);
      chk("restart_wr_reg", DW'(wr_reg), 1);
      chk("restart_wr_en", DW'(wr_en), 1);

      // Drain outstanding requests and compare the register file.
      for (int k = 0; k < 45; k++) step(1'b0);
      mon_en = 1'b0;
      for (int i = 1; i < 32; i++) chk("rf_final", rf[i], golden[i]);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
